// File: rtl/grayscale_wr_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : grayscale_wr_buffer_if
// Description : Pixel-result input and CCI-P c1 write-channel signals of the
//               grayscale write buffer, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface grayscale_wr_buffer_if #(
  parameter int IDX_W = 32
);

  // Result line from the grayscale pipeline (no backpressure possible)
  logic [511:0]     data_in;
  logic             valid_in;

  // Write channel towards the requestor
  logic             wr_ready;
  logic             wr_valid;
  logic [511:0]     wr_data;
  logic [IDX_W-1:0] wr_idx;

  // View taken by the buffer itself
  modport slave (
    input  data_in,
    input  valid_in,
    input  wr_ready,
    output wr_valid,
    output wr_data,
    output wr_idx
  );

  // View taken by the pipeline/requestor side
  modport master (
    output data_in,
    output valid_in,
    output wr_ready,
    input  wr_valid,
    input  wr_data,
    input  wr_idx
  );

endinterface
`default_nettype wire

// File: rtl/grayscale_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : grayscale_wr_buffer
// Description : Elastic FWFT output stage between the grayscale pipeline and
//               the CCI-P c1 write path. Tags each line with its index in the
//               job, throttles the requestor with almost_full, and pulses done
//               once the programmed number of lines has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module grayscale_wr_buffer #(
  parameter int DEPTH     = 64,
  parameter int AF_MARGIN = 16,
  parameter int IDX_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,      // asynchronous, active low
  input  logic                    start,
  input  logic [IDX_W-1:0]        num_lines,
  grayscale_wr_buffer_if.slave    wr_if,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Storage: RAM behind a registered output stage
  logic [511:0]     mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic             wr_valid_q, wr_valid_d;
  logic [511:0]     wr_data_q, wr_data_d;
  logic             af_q, af_d;

  // Job control
  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] num_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  // Per-cycle decisions
  logic             pop;
  logic             out_free;
  logic             push;
  logic             bypass;
  logic             ram_wr;
  logic             ram_rd;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    occ_d;

  // Datapath next-state: push/pop decisions, pointer and output-stage update
  always_comb begin
    pop      = wr_valid_q & wr_if.wr_ready;
    out_free = ~wr_valid_q | pop;
    occ      = ram_cnt_q + CW'(wr_valid_q);
    // A line is taken only while a job runs, never on a flush cycle, and when
    // there is room now or a slot frees up in the same cycle.
    push     = wr_if.valid_in & ~start & (state_q == S_RUN) &
               ((occ != FULL_LVL) | pop);
    // With an empty RAM and a free output stage the line skips the RAM so
    // that an empty buffer presents data the very next cycle.
    bypass   = push & (ram_cnt_q == '0) & out_free;
    ram_wr   = push & ~bypass;
    ram_rd   = out_free & (ram_cnt_q != '0);

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ram_cnt_d  = ram_cnt_q;
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;

    if (start) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      wr_valid_d = 1'b0;
    end else begin
      if (ram_wr) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (ram_rd) begin
        rptr_d = rptr_q + AW'(1);
      end
      ram_cnt_d = ram_cnt_q + CW'(ram_wr) - CW'(ram_rd);
      if (ram_rd) begin
        wr_valid_d = 1'b1;
        wr_data_d  = mem_q[rptr_q];
      end else if (bypass) begin
        wr_valid_d = 1'b1;
        wr_data_d  = wr_if.data_in;
      end else if (out_free) begin
        wr_valid_d = 1'b0;
      end
    end

    occ_d = ram_cnt_d + CW'(wr_valid_d);
    af_d  = (occ_d >= AF_LVL);
  end

  // Line storage; no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem_q[wptr_q] <= wr_if.data_in;
    end
  end

  // Datapath registers: pointers, counts, output stage and throttle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      af_q       <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      af_q       <= af_d;
    end
  end

  // Job state machine with registered busy/done/overflow and line index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // A start in any state restarts the job; an aborted job never
        // reports done.
        num_q <= num_lines;
        idx_q <= '0;
        ovf_q <= 1'b0;
        if (num_lines == '0) begin
          state_q <= S_FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
      end else begin
        if (pop) begin
          idx_q <= idx_q + IDX_W'(1);
        end
        if (wr_if.valid_in && !push) begin
          ovf_q <= 1'b1;
        end
        case (state_q)
          S_RUN: begin
            if (pop && (idx_q == num_q - IDX_W'(1))) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          S_FIN: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign wr_if.wr_valid = wr_valid_q;
  assign wr_if.wr_data  = wr_data_q;
  assign wr_if.wr_idx   = idx_q;
  assign almost_full    = af_q;
  assign occupancy      = occ;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_grayscale_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_grayscale_wr_buffer
// Description : Scoreboard bench for grayscale_wr_buffer with a queue-based
//               reference model of the job and buffer behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grayscale_wr_buffer;

  localparam int DEPTH     = 64;
  localparam int AF_MARGIN = 16;
  localparam int IDX_W     = 32;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [IDX_W-1:0]       num_lines = '0;
  logic                   almost_full;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  grayscale_wr_buffer_if #(.IDX_W(IDX_W)) bus ();

  grayscale_wr_buffer #(
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_lines   (num_lines),
    .wr_if       (bus),
    .almost_full (almost_full),
    .occupancy   (occupancy),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0]     data;
    logic [IDX_W-1:0] idx;
  } line_t;

  line_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Reference model: lines held, job progress, sticky flags
  int               m_cnt  = 0;
  int               m_rem  = 0;
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  bit               m_ovf  = 1'b0;
  bit               m_af   = 1'b0;
  logic [IDX_W-1:0] m_acc  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer must match the head of the scoreboard
  always @(negedge clk) begin
    line_t e;
    if (reset && bus.wr_valid && bus.wr_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_line: got idx %0d, expected no transfer at %0t", bus.wr_idx, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_data !== e.data || bus.wr_idx !== e.idx) begin
          n_bad++;
          $display("FAIL line: got idx %0d data[63:0] %h expected idx %0d data[63:0] %h at %0t",
                   bus.wr_idx, bus.wr_data[63:0], e.idx, e.data[63:0], $time);
        end
      end
    end
  end

  // One clock of stimulus: called just after a rising edge
  task automatic step(input bit v, input bit rdy, input bit st, input logic [IDX_W-1:0] n);
    logic [511:0] d;
    bit           pop;
    bit           take;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.wr_ready = rdy;
    start        = st;
    num_lines    = n;
    @(negedge clk);
    #1;
    chk("wr_valid",    64'(bus.wr_valid), 64'(m_cnt > 0));
    chk("occupancy",   64'(occupancy),    64'(m_cnt));
    chk("almost_full", 64'(almost_full),  64'(m_af));
    chk("overflow",    64'(overflow),     64'(m_ovf));
    chk("busy",        64'(busy),         64'(m_busy));
    chk("done",        64'(done),         64'(m_done));
    if (st) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_acc  = '0;
      m_rem  = int'(n);
      m_busy = (n != 0);
      m_done = (n == 0);
    end else begin
      pop    = (m_cnt > 0) && rdy;
      take   = v && m_busy && ((m_cnt < DEPTH) || pop);
      m_done = 1'b0;
      if (v && !take) m_ovf = 1'b1;
      if (pop) begin
        m_cnt--;
        if (m_busy) begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
      if (take) begin
        m_cnt++;
        exp_q.push_back('{data: d, idx: m_acc});
        m_acc++;
      end
    end
    m_af = (m_cnt >= DEPTH - AF_MARGIN);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rdy_pct;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.wr_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_wr_valid",    64'(bus.wr_valid),        64'(0));
    chk("rst_wr_data",     64'(bus.wr_data != '0),   64'(0));
    chk("rst_wr_idx",      64'(bus.wr_idx),          64'(0));
    chk("rst_occupancy",   64'(occupancy),           64'(0));
    chk("rst_almost_full", 64'(almost_full),         64'(0));
    chk("rst_busy",        64'(busy),                64'(0));
    chk("rst_done",        64'(done),                64'(0));
    chk("rst_overflow",    64'(overflow),            64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);

    // Basic four-line job, back-to-back with the write channel open
    step(0, 1, 1, 32'd4);
    for (int i = 0; i < 4; i++) step(1, 1, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0);

    // Fill to the threshold and to full, push-and-pop at full, then overflow
    step(0, 0, 1, 32'd100);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    step(1, 0, 0, '0);
    for (int i = 0; i < DEPTH + 6; i++) step(0, 1, 0, '0);

    // Abort a ten-line job midway; restart coincides with a valid line
    step(0, 0, 1, 32'd10);
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
    step(1, 1, 1, 32'd2);
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0);

    // Zero-length job, then a stray line while idle
    step(0, 1, 1, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    step(1, 1, 0, '0);
    step(0, 1, 0, '0);

    // Randomised jobs at several write-channel availabilities
    for (int r = 0; r < 3; r++) begin
      rdy_pct = (r == 0) ? 9 : ((r == 1) ? 5 : 2);
      step(0, 1, 1, IDX_W'($urandom_range(20, 120)));
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < rdy_pct, 0, '0);
      for (int i = 0; i < DEPTH + 4; i++) step(0, 1, 0, '0);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset in the middle of a job
    step(0, 0, 1, 32'd50);
    for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_wr_valid",    64'(bus.wr_valid), 64'(0));
    chk("arst_occupancy",   64'(occupancy),    64'(0));
    chk("arst_busy",        64'(busy),         64'(0));
    chk("arst_almost_full", 64'(almost_full),  64'(0));
    chk("arst_wr_idx",      64'(bus.wr_idx),   64'(0));
    exp_q.delete();
    m_cnt  = 0;
    m_rem  = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_af   = 1'b0;
    m_acc  = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1, 0, '0);
    step(1, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grayscale_wr_buffer.md
Name: grayscale_wr_buffer

Overview:
- Elastic output stage between the grayscale pixel pipeline (fixed latency, no backpressure) and the requestor's CCI-P c1 write path.
- Captures every 512-bit result line, holds it until the write channel can accept it, and tags each line with a sequential line index that the requestor turns into a write address.
- Drives an almost-full throttle back to the requestor so it stops issuing c0 reads before this buffer can overflow.
- Counts written lines against a programmed total and pulses done when the job completes.

Parameters:
DEPTH, 64, FIFO depth in 512-bit lines; power of two, minimum 4
AF_MARGIN, 16, free-slot margin; almost_full asserts when occupancy >= DEPTH-AF_MARGIN
IDX_W, 32, width of line index and line-count fields

Ports:
clk  in  1  single clock for the whole block (pClk domain)
reset  in  1  asynchronous, active-low reset; deasserts synchronously to clk
start  in  1  one-cycle pulse that begins a job
num_lines  in  IDX_W  total lines in the job; sampled on start
data_in  in  512  result line from the grayscale pipeline
valid_in  in  1  data_in valid; this stage cannot backpressure it
wr_ready  in  1  requestor can accept a write this cycle (!c1TxAlmFull and no conflict)
wr_valid  out  1  wr_data and wr_idx are valid
wr_data  out  512  line to write
wr_idx  out  IDX_W  0-based line index of wr_data within the job
almost_full  out  1  throttle for requestor read issue
occupancy  out  $clog2(DEPTH)+1  lines currently held, output register included
busy  out  1  job in progress
done  out  1  one-cycle pulse when the last line is accepted
overflow  out  1  sticky: a valid_in arrived while the buffer was full

Behaviour:
- Reset (reset=0, async) values:
  - outputs: wr_valid=0, wr_data=0, wr_idx=0, almost_full=0, occupancy=0, busy=0, done=0, overflow=0.
  - internals: FIFO pointers 0, state IDLE.
- Storage: DEPTH-entry RAM plus a registered output stage (first-word-fall-through); occupancy counts both.
- Handshake:
  - A transfer occurs when wr_valid & wr_ready.
  - wr_valid, wr_data and wr_idx hold stable until the transfer.
  - wr_valid never depends combinationally on wr_ready.
- Latency: valid_in at cycle N into an empty buffer gives wr_valid=1 at cycle N+1.
- Throughput: one line per cycle sustained when wr_ready=1 continuously.
- Simultaneous push and pop: both take effect; occupancy is unchanged; full-minus-one plus push-and-pop does not overflow.
- Full: valid_in while occupancy==DEPTH and no pop in the same cycle →
  - the line is dropped;
  - overflow is set and stays set;
  - occupancy is unchanged.
- Full plus push-and-pop in the same cycle is accepted.
- almost_full: registered, computed from next-cycle occupancy, so it is valid the cycle after the push that crosses the threshold.
- valid_in in IDLE (no job) is dropped and sets overflow.
- State machine:
  - IDLE: busy=0. On start: latch num_lines, clear wr_idx counter and overflow, go to RUN. If num_lines==0, go to FIN instead.
  - RUN: busy=1. Each transfer increments the index counter. The transfer whose index == num_lines-1 goes to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- wr_idx wraps at 2^IDX_W without error (not reachable with legal num_lines).
- start in RUN or FIN:
  - flushes the FIFO (occupancy→0, wr_valid→0 next cycle);
  - clears counters and overflow, re-latches num_lines, enters RUN;
  - no done pulse for the aborted job.
- start coincident with valid_in: the flush wins and that line is discarded.
- Lines beyond num_lines are not expected. If they arrive in RUN they are buffered; after FIN, further valid_in sets overflow.
- Async reset mid-job: immediate return to reset values; the next job needs a fresh start.

Test Plan:
- Reset, start num_lines=4, 4 valid_in on consecutive cycles, wr_ready=1 → wr_valid cycles N+1..N+4; wr_idx 0,1,2,3; data matches in order; done pulses one cycle after idx 3 transfer; busy then 0; overflow=0.
- DEPTH=64, AF_MARGIN=16, wr_ready=0, push 48 lines → almost_full=1 the cycle after the 48th push, 0 at occupancy 47; occupancy=48.
- wr_ready=0, push 65 lines → occupancy=64, overflow=1. Then wr_ready=1 → exactly 64 lines out, idx 0..63, in order.
- occupancy=64, valid_in and wr_ready both 1 in the same cycle → no overflow, occupancy stays 64, correct ordering.
- Job of 10, start pulsed again after 5 transfers with 3 lines buffered and num_lines=2 → buffer flushed, no done for first job, next 2 lines get idx 0,1, done pulses once.
- start with num_lines=0 → done pulses the cycle after start, busy never asserts, wr_valid stays 0.
